pss_sync_ctrl: RTL and testbench
================================

Name: pss_sync_ctrl

Overview:
- Timing-acquisition controller behind the three PSS correlators, one per N_id_2 hypothesis.
- Consumes their magnitude streams and searches for a threshold crossing. Tracks the maximum over a short window and reports peak position and N_id_2.
- Then locks: it checks only a window around each expected next SSB position and falls back to search after repeated misses.
- Feeds the SSS detector and CP/FFT timing logic.

Parameters:
IN_DW, 24, magnitude width per correlator output
CNT_DW, 24, sample counter / period width
WINDOW_LEN, 16, samples tracked after first crossing in SEARCH
MAX_MISS, 3, consecutive missed verifications before lock loss

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  run; low forces IDLE
threshold_i  in  IN_DW  detection threshold (strict >)
period_i  in  CNT_DW  expected peak spacing in samples; sampled on lock
tol_i  in  8  half-width of verify window; sampled on lock; requires 2*tol_i+1 < period_i
s_axis_in_tdata  in  3*IN_DW  magnitudes; N_id_2=k at bits [k*IN_DW +: IN_DW]
s_axis_in_tvalid  in  1  sample strobe; no backpressure
peak_valid_o  out  1  one-clock report pulse
peak_nid2_o  out  2  N_id_2 of reported peak
peak_idx_o  out  CNT_DW  sample index of reported peak
peak_mag_o  out  IN_DW  reported magnitude
locked_o  out  1  controller in LOCKED
state_o  out  2  current state, debug

Behaviour:
- Reset: all outputs 0, state IDLE, sample counter 0, miss counter 0.
- Sample counter: +1 per valid sample, free-running, wraps modulo 2^CNT_DW. The idx of a sample is the counter value before the increment.
- Per valid sample: best = max of the 3 magnitudes, unsigned. Ties go to the lowest N_id_2.
- States: IDLE=0, SEARCH=1, TRACK=2, LOCKED=3.
- IDLE: enable_i high -> SEARCH next clock. enable_i low in any state -> IDLE next clock; locked_o and miss counter cleared. The sample counter keeps running while valid samples arrive.
- SEARCH: on valid sample with best > threshold_i:
  - load candidate {mag, nid2, idx}, win_cnt=1
  - go to TRACK
- TRACK, on each valid sample:
  - best > cand_mag strictly -> replace candidate; the earliest sample wins ties
  - win_cnt++
  - when the sample bringing win_cnt to WINDOW_LEN is accepted: report candidate, go to LOCKED, latch period_i/tol_i/nid2, set dist = idx_now - cand_idx + 1 (mod 2^CNT_DW), miss=0
- LOCKED: dist = valid samples since last (reported or predicted) peak, +1 per valid sample.
  - Verify window: dist in [period-tol, period+tol].
  - Inside the window, track the max of the locked nid2 only, above threshold.
  - On the sample where dist == period+tol:
    - a candidate exists -> report it, miss=0, dist re-anchored to samples since the candidate
    - no candidate -> miss++ and dist = tol+1, i.e. re-anchored to the predicted position, no report
  - miss reaching MAX_MISS -> SEARCH, locked_o=0.
- Report: peak_valid_o high exactly one clock, the clock after the closing sample is accepted. peak_* are registered and hold until the next report.
- No report occurs outside TRACK->LOCKED or a LOCKED verify close.
- The closing sample of a window is itself eligible as candidate.
- Gaps in s_axis_in_tvalid stall all counters; nothing advances on non-valid clocks.
- locked_o = (state == LOCKED), registered.
- Async reset mid-window: immediate return to the reset values above. No pending report survives.

Decomposition:
- Package pss_sync_pkg holds:
  - state enum (IDLE/SEARCH/TRACK/LOCKED)
  - NID2_DW=2
  - NUM_NID2=3
  - localparam for the state width
- One sub-module pss_max3: combinational argmax of 3 magnitudes with lowest-index tie-break. Reused by the SSS path.

Test Plan:
- Zero input except a single spike of 1000 on nid2=1 at idx 100, threshold 500, WINDOW_LEN 16 -> one report {nid2=1, idx=100, mag=1000}, peak_valid_o 1 clock after idx 115 accepted; locked_o=1.
- Ramp crossing at idx 50 (600) with max 900 at idx 57 on nid2=2, 850 on nid2=0 at 57 -> report {2, 57, 900}. Equal 900 on nid2=0 and 2 -> nid2=0.
- Locked, period 200, tol 4, spikes every 200 with one at +3 jitter -> reports at exact idx each period, jittered one reported at its true idx, miss stays 0.
- Locked, MAX_MISS 3, spikes stop -> no reports. locked_o drops 1 clock after sample at period+tol of 3rd missed window; state_o=1.
- Spike on nid2=0 while locked to nid2=1 inside window -> ignored, counted as miss.
- enable_i low mid-TRACK, or reset_i pulse mid-LOCKED -> state 0 next clock (reset: immediately), no peak_valid_o, outputs 0 after reset. tvalid gaps of random length give identical reports to the gap-free run.

Source files
------------

// File: rtl/pss_sync_pkg.sv
// rtl/pss_sync_pkg.sv - shared types and constants for PSS timing acquisition
package pss_sync_pkg;

  localparam int NID2_DW  = 2;
  localparam int NUM_NID2 = 3;
  localparam int STATE_DW = 2;

  typedef enum logic [STATE_DW-1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

endpackage

// File: rtl/pss_max3.sv
// rtl/pss_max3.sv - unsigned argmax of three correlator magnitudes, lowest index wins ties
module pss_max3
  import pss_sync_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic [NUM_NID2*DW-1:0] i_mags,
  output logic [DW-1:0]          o_max,
  output logic [NID2_DW-1:0]     o_idx
);

  logic [DW-1:0] w_m0;
  logic [DW-1:0] w_m1;
  logic [DW-1:0] w_m2;

  assign w_m0 = i_mags[0*DW +: DW];
  assign w_m1 = i_mags[1*DW +: DW];
  assign w_m2 = i_mags[2*DW +: DW];

  // strict compares keep the earlier hypothesis on equal magnitudes
  always_comb begin
    o_max = w_m0;
    o_idx = 2'd0;
    if (w_m1 > o_max) begin
      o_max = w_m1;
      o_idx = 2'd1;
    end
    if (w_m2 > o_max) begin
      o_max = w_m2;
      o_idx = 2'd2;
    end
  end

endmodule

// File: rtl/pss_sync_ctrl.sv
// rtl/pss_sync_ctrl.sv - PSS search/track/lock controller reporting peak timing and N_id_2
module pss_sync_ctrl
  import pss_sync_pkg::*;
#(
  parameter int IN_DW      = 24,
  parameter int CNT_DW     = 24,
  parameter int WINDOW_LEN = 16,
  parameter int MAX_MISS   = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [IN_DW-1:0]          threshold_i,
  input  logic [CNT_DW-1:0]         period_i,
  input  logic [7:0]                tol_i,
  input  logic [NUM_NID2*IN_DW-1:0] s_axis_in_tdata,
  input  logic                      s_axis_in_tvalid,
  output logic                      peak_valid_o,
  output logic [NID2_DW-1:0]        peak_nid2_o,
  output logic [CNT_DW-1:0]         peak_idx_o,
  output logic [IN_DW-1:0]          peak_mag_o,
  output logic                      locked_o,
  output logic [STATE_DW-1:0]       state_o
);

  localparam int WIN_DW  = $clog2(WINDOW_LEN + 1);
  localparam int MISS_DW = $clog2(MAX_MISS + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_DW-1:0]   r_sample_cnt;
  logic [IN_DW-1:0]    r_cand_mag;
  logic [NID2_DW-1:0]  r_cand_nid2;
  logic [CNT_DW-1:0]   r_cand_idx;
  logic                r_cand_vld;
  logic [WIN_DW-1:0]   r_win_cnt;
  logic [NID2_DW-1:0]  r_lk_nid2;
  logic [CNT_DW-1:0]   r_period;
  logic [7:0]          r_tol;
  logic [CNT_DW-1:0]   r_dist;
  logic [MISS_DW-1:0]  r_miss;
  logic                r_peak_valid;
  logic [NID2_DW-1:0]  r_peak_nid2;
  logic [CNT_DW-1:0]   r_peak_idx;
  logic [IN_DW-1:0]    r_peak_mag;
  logic                r_locked;

  logic [IN_DW-1:0]    w_best;
  logic [NID2_DW-1:0]  w_best_nid2;
  logic [IN_DW-1:0]    w_lk_mag;
  logic [CNT_DW:0]     w_win_lo;
  logic [CNT_DW:0]     w_win_hi;
  logic                w_acc;
  logic                w_cross;
  logic                w_take;
  logic                w_track_close;
  logic                w_lk_close;
  logic                w_lk_found;
  logic                w_miss_out;
  logic                w_report;
  logic [IN_DW-1:0]    w_fin_mag;
  logic [NID2_DW-1:0]  w_fin_nid2;
  logic [CNT_DW-1:0]   w_fin_idx;
  logic [CNT_DW-1:0]   w_fin_dist;

  pss_max3 #(.DW(IN_DW)) u_max3 (
    .i_mags (s_axis_in_tdata),
    .o_max  (w_best),
    .o_idx  (w_best_nid2)
  );

  assign w_lk_mag = s_axis_in_tdata[r_lk_nid2*IN_DW +: IN_DW];
  assign w_win_lo = {1'b0, r_period} - (CNT_DW+1)'(r_tol);
  assign w_win_hi = {1'b0, r_period} + (CNT_DW+1)'(r_tol);

  // state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state: enable low always wins, lock is lost only after MAX_MISS empty windows
  always_comb begin
    w_state_nxt = r_state;
    if (!enable_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_SEARCH;
        ST_SEARCH: if (w_cross)       w_state_nxt = ST_TRACK;
        ST_TRACK:  if (w_track_close) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (w_lk_close && !w_lk_found && w_miss_out) w_state_nxt = ST_SEARCH;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // per-sample event decode; the current sample may itself become the final candidate
  always_comb begin
    w_acc         = s_axis_in_tvalid && enable_i;
    w_cross       = w_acc && (r_state == ST_SEARCH) && (w_best > threshold_i);
    w_track_close = w_acc && (r_state == ST_TRACK) && (r_win_cnt == WIN_DW'(WINDOW_LEN - 1));
    w_lk_close    = w_acc && (r_state == ST_LOCKED) && ({1'b0, r_dist} == w_win_hi);
    w_take        = 1'b0;
    w_fin_mag     = r_cand_mag;
    w_fin_nid2    = r_cand_nid2;
    w_fin_idx     = r_cand_idx;
    if (w_acc && (r_state == ST_TRACK) && (w_best > r_cand_mag)) begin
      w_take     = 1'b1;
      w_fin_mag  = w_best;
      w_fin_nid2 = w_best_nid2;
      w_fin_idx  = r_sample_cnt;
    end else if (w_acc && (r_state == ST_LOCKED) &&
                 ({1'b0, r_dist} >= w_win_lo) && ({1'b0, r_dist} <= w_win_hi) &&
                 (w_lk_mag > threshold_i) && (!r_cand_vld || (w_lk_mag > r_cand_mag))) begin
      w_take     = 1'b1;
      w_fin_mag  = w_lk_mag;
      w_fin_nid2 = r_lk_nid2;
      w_fin_idx  = r_sample_cnt;
    end
    w_lk_found = r_cand_vld || (w_take && (r_state == ST_LOCKED));
    w_miss_out = ((r_miss + MISS_DW'(1)) == MISS_DW'(MAX_MISS));
    w_report   = w_track_close || (w_lk_close && w_lk_found);
    w_fin_dist = r_sample_cnt - w_fin_idx + CNT_DW'(1);
  end

  // datapath: counters, candidate, lock parameters and registered report
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sample_cnt <= '0;
      r_cand_mag   <= '0;
      r_cand_nid2  <= '0;
      r_cand_idx   <= '0;
      r_cand_vld   <= 1'b0;
      r_win_cnt    <= '0;
      r_lk_nid2    <= '0;
      r_period     <= '0;
      r_tol        <= '0;
      r_dist       <= '0;
      r_miss       <= '0;
      r_peak_valid <= 1'b0;
      r_peak_nid2  <= '0;
      r_peak_idx   <= '0;
      r_peak_mag   <= '0;
      r_locked     <= 1'b0;
    end else begin
      r_peak_valid <= w_report;
      r_locked     <= (w_state_nxt == ST_LOCKED);
      if (s_axis_in_tvalid) r_sample_cnt <= r_sample_cnt + CNT_DW'(1);
      if (w_report) begin
        r_peak_mag  <= w_fin_mag;
        r_peak_nid2 <= w_fin_nid2;
        r_peak_idx  <= w_fin_idx;
      end
      if (!enable_i) begin
        r_miss     <= '0;
        r_cand_vld <= 1'b0;
      end else if (w_acc) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_cross) begin
              r_cand_mag  <= w_best;
              r_cand_nid2 <= w_best_nid2;
              r_cand_idx  <= r_sample_cnt;
              r_win_cnt   <= WIN_DW'(1);
            end
          end
          ST_TRACK: begin
            if (w_take) begin
              r_cand_mag  <= w_fin_mag;
              r_cand_nid2 <= w_fin_nid2;
              r_cand_idx  <= w_fin_idx;
            end
            r_win_cnt <= r_win_cnt + WIN_DW'(1);
            if (w_track_close) begin
              r_lk_nid2  <= w_fin_nid2;
              r_period   <= period_i;
              r_tol      <= tol_i;
              r_dist     <= w_fin_dist;
              r_miss     <= '0;
              r_cand_vld <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (w_lk_close) begin
              r_cand_vld <= 1'b0;
              if (w_lk_found) begin
                r_dist <= w_fin_dist;
                r_miss <= '0;
              end else if (w_miss_out) begin
                r_miss <= '0;
              end else begin
                r_miss <= r_miss + MISS_DW'(1);
                r_dist <= CNT_DW'(r_tol) + CNT_DW'(1);
              end
            end else begin
              r_dist <= r_dist + CNT_DW'(1);
              if (w_take) begin
                r_cand_mag  <= w_fin_mag;
                r_cand_nid2 <= w_fin_nid2;
                r_cand_idx  <= w_fin_idx;
                r_cand_vld  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign peak_valid_o = r_peak_valid;
  assign peak_nid2_o  = r_peak_nid2;
  assign peak_idx_o   = r_peak_idx;
  assign peak_mag_o   = r_peak_mag;
  assign locked_o     = r_locked;
  assign state_o      = r_state;

endmodule

// File: tb/tb_pss_sync_ctrl.sv
// tb/tb_pss_sync_ctrl.sv - scoreboard bench for pss_sync_ctrl
module tb_pss_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] thr;
  logic [23:0] per;
  logic [7:0]  tol;
  logic [71:0] tdata;
  logic        tvalid;
  logic        peak_valid_o;
  logic [1:0]  peak_nid2_o;
  logic [23:0] peak_idx_o;
  logic [23:0] peak_mag_o;
  logic        locked_o;
  logic [1:0]  state_o;

  typedef struct {
    int nid2;
    int idx;
    int mag;
    int close_idx;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_err    = 0;
  int   n_rep    = 0;
  int   tb_cnt   = 0;
  int   last_idx = -1;
  bit   use_gaps = 1'b0;

  pss_sync_ctrl #(
    .IN_DW(24), .CNT_DW(24), .WINDOW_LEN(16), .MAX_MISS(3)
  ) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .enable_i         (en),
    .threshold_i      (thr),
    .period_i         (per),
    .tol_i            (tol),
    .s_axis_in_tdata  (tdata),
    .s_axis_in_tvalid (tvalid),
    .peak_valid_o     (peak_valid_o),
    .peak_nid2_o      (peak_nid2_o),
    .peak_idx_o       (peak_idx_o),
    .peak_mag_o       (peak_mag_o),
    .locked_o         (locked_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input int n, input int i, input int m, input int c);
    exp_t e;
    e.nid2 = n; e.idx = i; e.mag = m; e.close_idx = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (peak_valid_o === 1'b1) begin
      exp_t e;
      n_rep++;
      if (sb.size() == 0) begin
        check("unexpected_report_idx", 64'(peak_idx_o), 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("rep_nid2",  64'(peak_nid2_o), 64'(e.nid2));
        check("rep_idx",   64'(peak_idx_o),  64'(e.idx));
        check("rep_mag",   64'(peak_mag_o),  64'(e.mag));
        check("rep_close", 64'(last_idx),    64'(e.close_idx));
      end
    end
  end

  task automatic send(input logic [23:0] m0, input logic [23:0] m1, input logic [23:0] m2);
    int g;
    g = use_gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin
      tdata = {24'($urandom), 24'($urandom), 24'($urandom)};
      @(negedge clk);
    end
    tdata  = {m2, m1, m0};
    tvalid = 1'b1;
    @(posedge clk);
    last_idx = tb_cnt;
    tb_cnt++;
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; tvalid = 1'b0; rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; tb_cnt = 0;
  endtask

  task automatic start_run();
    en = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic lock_seq();
    logic [23:0] a, b, c;
    for (int i = 0; i <= 1307; i++) begin
      a = 0; b = 0; c = 0;
      case (i)
        40:   c = 500;
        100:  begin b = 1000; push(1, 100, 1000, 115); end
        300:  begin b = 1100; push(1, 300, 1100, 304); end
        503:  begin b = 1200; push(1, 503, 1200, 504); end
        703:  begin b = 1300; push(1, 703, 1300, 707); end
        1000: b = 5000;
        1103: a = 4000;
        default: ;
      endcase
      send(a, b, c);
      if (i == 115) begin
        check("lock_locked", 64'(locked_o), 64'd1);
        check("lock_state",  64'(state_o),  64'd3);
      end
      if (i == 1306) check("preloss_locked", 64'(locked_o), 64'd1);
      if (i == 1307) begin
        check("loss_locked", 64'(locked_o), 64'd0);
        check("loss_state",  64'(state_o),  64'd1);
      end
    end
  endtask

  task automatic ramp_seq(input bit tie);
    logic [23:0] a, b, c;
    for (int i = 0; i <= 70; i++) begin
      a = 0; b = 0; c = 0;
      case (i)
        50: c = 600;
        51: c = 650;
        52: c = 700;
        53: c = 750;
        54: c = 800;
        55: c = 850;
        56: c = 880;
        57: begin
          c = 900;
          a = tie ? 24'd900 : 24'd850;
          push(tie ? 0 : 2, 57, 900, 65);
        end
        default: if (i >= 58 && i <= 65) c = 800;
      endcase
      if (tie && i == 60) b = 900;
      send(a, b, c);
    end
    check("ramp_locked", 64'(locked_o), 64'd1);
  endtask

  initial begin
    thr = 24'd500; per = 24'd200; tol = 8'd4;
    en = 1'b0; rst = 1'b1; tvalid = 1'b0; tdata = '0;
    do_reset();
    check("rst_valid",  64'(peak_valid_o), 64'd0);
    check("rst_nid2",   64'(peak_nid2_o),  64'd0);
    check("rst_idx",    64'(peak_idx_o),   64'd0);
    check("rst_mag",    64'(peak_mag_o),   64'd0);
    check("rst_locked", 64'(locked_o),     64'd0);
    check("rst_state",  64'(state_o),      64'd0);
    en = 1'b1;
    @(negedge clk);
    check("idle_to_search", 64'(state_o), 64'd1);
    @(negedge clk);
    lock_seq();

    do_reset(); start_run();
    use_gaps = 1'b1;
    lock_seq();
    use_gaps = 1'b0;

    do_reset(); start_run(); ramp_seq(1'b0);
    do_reset(); start_run(); ramp_seq(1'b1);

    do_reset(); start_run();
    for (int i = 0; i <= 40; i++) begin
      if (i == 14) en = 1'b0;
      send((i == 10 || i == 20) ? 24'd700 : 24'd0, 24'd0, 24'd0);
      if (i == 14) check("en_low_state", 64'(state_o), 64'd0);
    end
    check("en_low_state_end",  64'(state_o),  64'd0);
    check("en_low_locked_end", 64'(locked_o), 64'd0);

    do_reset(); start_run();
    for (int i = 0; i <= 301; i++) begin
      if (i == 100) push(1, 100, 1000, 115);
      send(24'd0, (i == 100) ? 24'd1000 : ((i == 299) ? 24'd2000 : 24'd0), 24'd0);
    end
    check("pre_rst_state", 64'(state_o), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_state",  64'(state_o),      64'd0);
    check("arst_locked", 64'(locked_o),     64'd0);
    check("arst_idx",    64'(peak_idx_o),   64'd0);
    check("arst_mag",    64'(peak_mag_o),   64'd0);
    check("arst_valid",  64'(peak_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0; tb_cnt = 0;
    for (int i = 0; i < 20; i++) send(24'd0, 24'd0, 24'd0);
    check("post_rst_mag", 64'(peak_mag_o), 64'd0);

    repeat (3) @(negedge clk);
    check("sb_drained",   64'(sb.size()), 64'd0);
    check("report_count", 64'(n_rep),     64'd11);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
